output_display: RTL and testbench

Downstream consumer of the machine's output register. It captures each 8-bit value written to `out` and converts it to up to three BCD digits plus a sign, using a sequential double-dabble converter. It then time-multiplexes the four digits onto a common 7-segment display. Its job is the same as the hobby build's EEPROM-decoded output display, in RTL form.

---
 rtl/output_display_if.sv | 21 ++
 rtl/output_display.sv | 201 ++++++++++++++++++++
 tb/tb_output_display.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/output_display_if.sv
// Bus between the machine's output register and the output display:
// write strobe and byte in, segment/digit drive and status out.
interface output_display_if;
  logic       load;
  logic [7:0] value;
  logic       signed_mode;
  logic [6:0] seg;
  logic [3:0] an;
  logic       busy;
  logic [7:0] shown;

  modport master (
    output load, value, signed_mode,
    input  seg, an, busy, shown
  );

  modport slave (
    input  load, value, signed_mode,
    output seg, an, busy, shown
  );
endinterface

// File: rtl/output_display.sv
// Output-register display: captures written bytes, converts them to sign plus
// three BCD digits with a sequential double-dabble, and multiplexes a 4-digit 7-seg.
module output_display #(
  parameter int unsigned REFRESH_DIV   = 1000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  output_display_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_COMMIT} state_e;

  state_e     state_q, state_d;
  logic       busy, start, step, commit;

  logic [2:0] iter_q, iter_d;
  logic [7:0] mag_q, mag_d;
  logic [9:0] bcd_q, bcd_d;
  logic       sign_q, sign_d;
  logic [7:0] raw_q, raw_d;

  logic       pend_q, pend_d;
  logic [7:0] pend_val_q, pend_val_d;
  logic       pend_sgn_q, pend_sgn_d;

  logic [3:0] ones_q, ones_d, tens_q, tens_d;
  logic [1:0] hund_q, hund_d;
  logic       neg_q, neg_d;
  logic [7:0] shown_q, shown_d;

  logic [15:0] presc_q, presc_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  an_q, an_d;

  logic [7:0] src_val, src_mag;
  logic       src_sgn, src_neg;
  logic [9:0] bcd_adj;
  logic       wrap, blank_h, blank_t;
  logic [6:0] seg;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0111111;
      4'd1:    seg7 = 7'b0000110;
      4'd2:    seg7 = 7'b1011011;
      4'd3:    seg7 = 7'b1001111;
      4'd4:    seg7 = 7'b1100110;
      4'd5:    seg7 = 7'b1101101;
      4'd6:    seg7 = 7'b1111101;
      4'd7:    seg7 = 7'b0000111;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1101111;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (bus.load || pend_q) state_d = S_CONVERT;
      S_CONVERT: if (iter_q == 3'd7)     state_d = S_COMMIT;
      S_COMMIT:                          state_d = S_IDLE;
      default:                           state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q != S_IDLE);
    start  = (state_q == S_IDLE) && (bus.load || pend_q);
    step   = (state_q == S_CONVERT);
    commit = (state_q == S_COMMIT);
  end

  // A fresh strobe in IDLE takes priority over the pending slot.
  always_comb begin
    src_val = bus.load ? bus.value : pend_val_q;
    src_sgn = bus.load ? bus.signed_mode : pend_sgn_q;
    src_neg = src_sgn && src_val[7];
    src_mag = src_neg ? (~src_val + 8'd1) : src_val;

    bcd_adj = bcd_q;
    if (bcd_adj[3:0] >= 4'd5) bcd_adj[3:0] = bcd_adj[3:0] + 4'd3;
    if (bcd_adj[7:4] >= 4'd5) bcd_adj[7:4] = bcd_adj[7:4] + 4'd3;
  end

  always_comb begin
    iter_d     = iter_q;
    mag_d      = mag_q;
    bcd_d      = bcd_q;
    sign_d     = sign_q;
    raw_d      = raw_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    pend_sgn_d = pend_sgn_q;
    ones_d     = ones_q;
    tens_d     = tens_q;
    hund_d     = hund_q;
    neg_d      = neg_q;
    shown_d    = shown_q;

    if (start) begin
      mag_d  = src_mag;
      bcd_d  = '0;
      sign_d = src_neg;
      raw_d  = src_val;
      iter_d = '0;
      pend_d = 1'b0;
    end
    if (step) begin
      bcd_d  = {bcd_adj[8:0], mag_q[7]};
      mag_d  = {mag_q[6:0], 1'b0};
      iter_d = iter_q + 3'd1;
    end
    if (busy && bus.load) begin
      pend_d     = 1'b1;
      pend_val_d = bus.value;
      pend_sgn_d = bus.signed_mode;
    end
    if (commit) begin
      ones_d  = bcd_q[3:0];
      tens_d  = bcd_q[7:4];
      hund_d  = bcd_q[9:8];
      neg_d   = sign_q;
      shown_d = raw_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      iter_q     <= '0;
      mag_q      <= '0;
      bcd_q      <= '0;
      sign_q     <= 1'b0;
      raw_q      <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      pend_sgn_q <= 1'b0;
      ones_q     <= '0;
      tens_q     <= '0;
      hund_q     <= '0;
      neg_q      <= 1'b0;
      shown_q    <= '0;
    end else begin
      iter_q     <= iter_d;
      mag_q      <= mag_d;
      bcd_q      <= bcd_d;
      sign_q     <= sign_d;
      raw_q      <= raw_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      pend_sgn_q <= pend_sgn_d;
      ones_q     <= ones_d;
      tens_q     <= tens_d;
      hund_q     <= hund_d;
      neg_q      <= neg_d;
      shown_q    <= shown_d;
    end
  end

  always_comb begin
    wrap    = (presc_q == 16'(REFRESH_DIV - 1));
    presc_d = wrap ? '0 : presc_q + 16'd1;
    idx_d   = wrap ? idx_q + 2'd1 : idx_q;
    an_d    = 4'b0001 << idx_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      idx_q   <= '0;
      an_q    <= 4'b0001;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
    end
  end

  always_comb begin
    blank_h = BLANK_LEADING && (hund_q == 2'd0);
    blank_t = blank_h && (tens_q == 4'd0);
    case (idx_q)
      2'd0:    seg = seg7(ones_q);
      2'd1:    seg = blank_t ? 7'b0000000 : seg7(tens_q);
      2'd2:    seg = blank_h ? 7'b0000000 : seg7({2'b00, hund_q});
      default: seg = neg_q ? 7'b1000000 : 7'b0000000;
    endcase
  end

  assign bus.seg   = seg;
  assign bus.an    = an_q;
  assign bus.busy  = busy;
  assign bus.shown = shown_q;

endmodule

// File: tb/tb_output_display.sv
// Directed bench for output_display: two instances (leading blanking on/off)
// driven with identical stimulus, REFRESH_DIV=4 to keep refresh frames short.
module tb_output_display;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  output_display_if bus ();
  output_display_if bus_nb ();

  output_display #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  output_display #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .bus(bus_nb)
  );

  localparam logic [6:0] BLK   = 7'b0000000;
  localparam logic [6:0] MINUS = 7'b1000000;
  localparam logic [6:0] SEGS [10] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111
  };
  localparam logic [3:0] SEL [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  string slot_name [4] = '{"ones", "tens", "hund", "sign"};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic [7:0] v, input logic sm);
    bus.load = ld;    bus.value = v;    bus.signed_mode = sm;
    bus_nb.load = ld; bus_nb.value = v; bus_nb.signed_mode = sm;
  endtask

  task automatic pulse_reset;
    reset = 1'b1;
    tick;
    reset = 1'b0;
  endtask

  // One-cycle load, then wait (bounded) for the conversion to finish.
  task automatic convert(input logic [7:0] v, input logic sm, output int n);
    drive(1'b1, v, sm);
    tick;
    drive(1'b0, 8'h00, 1'b0);
    n = 0;
    while (bus.busy && n < 30) begin
      tick;
      n++;
    end
  endtask

  task automatic get_seg(input bit nb, input logic [3:0] sel,
                         output logic [6:0] s, output bit ok);
    ok = 1'b0;
    s  = '0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if ((nb ? bus_nb.an : bus.an) == sel) begin
        ok = 1'b1;
        s  = nb ? bus_nb.seg : bus.seg;
      end else begin
        tick;
      end
    end
  endtask

  task automatic test_reset;
    drive(1'b0, 8'h00, 1'b0);
    reset = 1'b1;
    tick;
    tick;
    checks++; if (bus.an !== 4'b0001) begin errors++; $display("FAIL reset_an got %b want 0001", bus.an); end
    checks++; if (bus.seg !== SEGS[0]) begin errors++; $display("FAIL reset_seg got %b want %b", bus.seg, SEGS[0]); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.shown !== 8'd0) begin errors++; $display("FAIL reset_shown got %0d want 0", bus.shown); end
    reset = 1'b0;
  endtask

  task automatic test_unsigned_max;
    logic [6:0] exp [4];
    logic [6:0] s;
    bit ok;
    int n;
    drive(1'b1, 8'd255, 1'b0);
    tick;
    drive(1'b0, 8'h00, 1'b0);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL max_busy_rise got %b want 1", bus.busy); end
    n = 0;
    while (bus.busy && n < 30) begin
      tick;
      n++;
    end
    checks++; if (n != 9) begin errors++; $display("FAIL max_busy_len got %0d want 9", n); end
    checks++; if (bus.shown !== 8'd255) begin errors++; $display("FAIL max_shown got %0d want 255", bus.shown); end
    exp = '{SEGS[5], SEGS[5], SEGS[2], BLK};
    for (int k = 0; k < 4; k++) begin
      get_seg(1'b0, SEL[k], s, ok);
      checks++;
      if (!ok || s !== exp[k]) begin errors++; $display("FAIL max_%s got %b want %b", slot_name[k], s, exp[k]); end
    end
  endtask

  task automatic test_signed;
    logic [6:0] exp [4];
    logic [6:0] s;
    bit ok;
    int n;
    convert(8'hFF, 1'b1, n);
    checks++; if (bus.shown !== 8'hFF) begin errors++; $display("FAIL neg1_shown got %h want ff", bus.shown); end
    exp = '{SEGS[1], BLK, BLK, MINUS};
    for (int k = 0; k < 4; k++) begin
      get_seg(1'b0, SEL[k], s, ok);
      checks++;
      if (!ok || s !== exp[k]) begin errors++; $display("FAIL neg1_%s got %b want %b", slot_name[k], s, exp[k]); end
    end
    convert(8'h80, 1'b1, n);
    checks++; if (bus.shown !== 8'h80) begin errors++; $display("FAIL neg128_shown got %h want 80", bus.shown); end
    exp = '{SEGS[8], SEGS[2], SEGS[1], MINUS};
    for (int k = 0; k < 4; k++) begin
      get_seg(1'b0, SEL[k], s, ok);
      checks++;
      if (!ok || s !== exp[k]) begin errors++; $display("FAIL neg128_%s got %b want %b", slot_name[k], s, exp[k]); end
    end
  endtask

  task automatic test_no_blank;
    logic [6:0] exp [4];
    logic [6:0] s;
    bit ok;
    int n;
    convert(8'd5, 1'b1, n);
    exp = '{SEGS[5], SEGS[0], SEGS[0], BLK};
    for (int k = 0; k < 4; k++) begin
      get_seg(1'b1, SEL[k], s, ok);
      checks++;
      if (!ok || s !== exp[k]) begin errors++; $display("FAIL noblank_%s got %b want %b", slot_name[k], s, exp[k]); end
    end
    exp = '{SEGS[5], BLK, BLK, BLK};
    for (int k = 0; k < 4; k++) begin
      get_seg(1'b0, SEL[k], s, ok);
      checks++;
      if (!ok || s !== exp[k]) begin errors++; $display("FAIL blank5_%s got %b want %b", slot_name[k], s, exp[k]); end
    end
  endtask

  task automatic test_collision;
    pulse_reset;
    drive(1'b1, 8'd5, 1'b0);
    tick;                                   // t
    drive(1'b0, 8'h00, 1'b0);
    tick;
    tick;
    drive(1'b1, 8'd7, 1'b0);
    tick;                                   // t+3
    drive(1'b1, 8'd9, 1'b0);
    tick;                                   // t+4
    drive(1'b0, 8'h00, 1'b0);
    repeat (4) tick;                        // t+8
    checks++; if (bus.shown !== 8'd0) begin errors++; $display("FAIL coll_early_shown got %0d want 0", bus.shown); end
    tick;                                   // t+9
    checks++; if (bus.shown !== 8'd5) begin errors++; $display("FAIL coll_first_shown got %0d want 5", bus.shown); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL coll_dip got %b want 0", bus.busy); end
    tick;                                   // t+10
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL coll_restart got %b want 1", bus.busy); end
    repeat (8) tick;                        // t+18
    checks++; if (bus.shown !== 8'd5) begin errors++; $display("FAIL coll_hold_shown got %0d want 5", bus.shown); end
    tick;                                   // t+19
    checks++; if (bus.shown !== 8'd9) begin errors++; $display("FAIL coll_second_shown got %0d want 9", bus.shown); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL coll_end_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_refresh;
    logic [3:0] exp;
    pulse_reset;
    for (int k = 0; k <= 16; k++) begin
      exp = SEL[(k / 4) % 4];
      checks++;
      if (bus.an !== exp) begin errors++; $display("FAIL refresh_an_%0d got %b want %b", k, bus.an, exp); end
      tick;
    end
    repeat (5) tick;                        // prescaler at 2, second slot
    checks++; if (bus.an !== 4'b0010) begin errors++; $display("FAIL refresh_preabort_an got %b want 0010", bus.an); end
    pulse_reset;
    for (int k = 0; k <= 4; k++) begin
      exp = (k < 4) ? 4'b0001 : 4'b0010;
      checks++;
      if (bus.an !== exp) begin errors++; $display("FAIL refresh_rst_an_%0d got %b want %b", k, bus.an, exp); end
      tick;
    end
  endtask

  task automatic test_abort;
    pulse_reset;
    drive(1'b1, 8'd200, 1'b0);
    tick;                                   // E0
    drive(1'b0, 8'h00, 1'b0);
    repeat (3) tick;
    reset = 1'b1;
    tick;                                   // E4
    reset = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", bus.busy); end
    repeat (12) tick;
    checks++; if (bus.shown !== 8'd0) begin errors++; $display("FAIL abort_shown got %0d want 0", bus.shown); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy_late got %b want 0", bus.busy); end
  endtask

  task automatic test_reset_load;
    drive(1'b1, 8'd77, 1'b0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstload_busy got %b want 0", bus.busy); end
    repeat (12) tick;
    checks++; if (bus.shown !== 8'd0) begin errors++; $display("FAIL rstload_shown got %0d want 0", bus.shown); end
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    test_reset;
    test_unsigned_max;
    test_signed;
    test_no_blank;
    test_collision;
    test_refresh;
    test_abort;
    test_reset_load;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
